light_hash_param: RTL and testbench

Parametrised successor of the light hash engine. Digest width, round count, rounds per cycle, IV and length-counter width are all parameters. Adds a proper valid/ready command handshake, message-length strengthening at finalisation, and a protocol-error flag. It sits between the byte-stream front end (UART/bench driver) and the digest consumer, and reuses the team's AES S-box combinational block.

---
 rtl/light_hash_param.sv | 234 +++++++++++++++++++++++
 tb/tb_light_hash_param.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_hash_param.sv
// -----------------------------------------------------------------------------
// light_hash_param
//
// Parametrised byte-serial hash engine. A session is opened with HEAD, bytes
// are absorbed with MSG (ROUNDS S-box rounds each, UNROLL rounds per clock),
// and TAIL closes the session by absorbing the message length (LEN_W/8 bytes,
// LSB first) before publishing the digest.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   cmd_valid     command/byte offered
//   cmd_ready     engine can accept a command this cycle
//   cmd           00 HEAD, 01 TAIL, 10 MSG, 11 reserved
//   msg_byte      data byte, sampled only on an accepted MSG
//   digest        final hash value (DIGEST_W bits)
//   digest_ready  digest valid; held until the next accepted HEAD or reset
//   busy          high while rounds are being computed (ROUND or FINAL)
//   proto_err     one-cycle pulse after an illegal command was accepted
//   state_dbg     current FSM state encoding, for observation only
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on the registered state, so
// it never combinationally depends on cmd_valid; while cmd_ready is low the
// cmd and msg_byte inputs are ignored.
// -----------------------------------------------------------------------------
module light_hash_param #(
    parameter int                  DIGEST_W = 64,
    parameter int                  ROUNDS   = 32,
    parameter int                  UNROLL   = 1,
    parameter logic [DIGEST_W-1:0] IV       = DIGEST_W'(64'h0123456789ABCDEF),
    parameter int                  LEN_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd,
    input  logic [7:0]          msg_byte,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_ready,
    output logic                busy,
    output logic                proto_err,
    output logic [2:0]          state_dbg
);

    localparam int NB    = DIGEST_W / 8;
    localparam int N     = ROUNDS / UNROLL;           // cycles per absorbed byte
    localparam int LB    = LEN_W / 8;                 // length bytes at finalisation
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int LI_W  = (LB > 1) ? $clog2(LB) : 1;

    localparam logic [1:0] CMD_HEAD = 2'b00;
    localparam logic [1:0] CMD_TAIL = 2'b01;
    localparam logic [1:0] CMD_MSG  = 2'b10;
    localparam logic [1:0] CMD_RSV  = 2'b11;

    // AES forward S-box
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_ROUND  = 3'd2,
        S_FINAL  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state;
    logic [DIGEST_W-1:0] h;          // chaining value
    logic [LEN_W-1:0]    len;        // bytes absorbed this session (wrapping)
    logic [LEN_W-1:0]    len_sh;     // length being absorbed, shifted right per byte
    logic [7:0]          byte_r;     // message byte being absorbed
    logic [CNT_W-1:0]    rnd_cnt;    // cycle within the current byte
    logic [LI_W-1:0]     len_idx;    // length byte index during FINAL

    logic                fire;
    logic [7:0]          absorb_byte;
    logic [2:0]          rot_base;
    logic [DIGEST_W-1:0] h_next;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] s);
        logic [15:0] t;
        t = {v, v} << s;
        return t[15:8];
    endfunction

    assign cmd_ready = (state == S_IDLE) || (state == S_ACCEPT) || (state == S_DONE);
    assign busy      = (state == S_ROUND) || (state == S_FINAL);
    assign state_dbg = state;
    assign fire      = cmd_valid && cmd_ready;

    assign absorb_byte = (state == S_FINAL) ? len_sh[7:0] : byte_r;

    // Absolute round index of the first round this cycle is rnd_cnt*UNROLL;
    // only its value mod 8 matters for the byte rotation.
    assign rot_base = 3'(32'(rnd_cnt) * 32'(UNROLL));

    // UNROLL chained rounds; every byte of a round reads the pre-round state.
    always_comb begin : round_chain
        logic [DIGEST_W-1:0] cur;
        logic [DIGEST_W-1:0] nxt;
        logic [7:0]          mr;
        cur = h;
        nxt = '0;
        mr  = '0;
        for (int u = 0; u < UNROLL; u++) begin
            mr  = rotl8(absorb_byte, rot_base + 3'(u));
            nxt = '0;
            for (int i = 0; i < NB; i++) begin
                nxt[8*i +: 8] = SBOX[cur[8*((i + 2) % NB) +: 8] ^ mr] ^ cur[8*i +: 8];
            end
            cur = nxt;
        end
        h_next = cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            h            <= IV;
            len          <= '0;
            len_sh       <= '0;
            byte_r       <= '0;
            rnd_cnt      <= '0;
            len_idx      <= '0;
            digest       <= '0;
            digest_ready <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fire) begin
                        if (cmd == CMD_HEAD) begin
                            h     <= IV;
                            len   <= '0;
                            state <= S_ACCEPT;
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end
                end

                S_ACCEPT: begin
                    if (fire) begin
                        case (cmd)
                            CMD_HEAD: begin
                                h   <= IV;
                                len <= '0;
                            end
                            CMD_MSG: begin
                                byte_r  <= msg_byte;
                                rnd_cnt <= '0;
                                state   <= S_ROUND;
                            end
                            CMD_TAIL: begin
                                len_sh  <= len;
                                len_idx <= '0;
                                rnd_cnt <= '0;
                                state   <= S_FINAL;
                            end
                            CMD_RSV: begin
                                proto_err <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end

                S_ROUND: begin
                    h <= h_next;
                    if (rnd_cnt == CNT_W'(N - 1)) begin
                        len   <= len + LEN_W'(1);
                        state <= S_ACCEPT;
                    end else begin
                        rnd_cnt <= rnd_cnt + CNT_W'(1);
                    end
                end

                S_FINAL: begin
                    h <= h_next;
                    if (rnd_cnt == CNT_W'(N - 1)) begin
                        rnd_cnt <= '0;
                        len_sh  <= len_sh >> 8;
                        if (len_idx == LI_W'(LB - 1)) begin
                            digest       <= h_next;
                            digest_ready <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            len_idx <= len_idx + LI_W'(1);
                        end
                    end else begin
                        rnd_cnt <= rnd_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    if (fire) begin
                        if (cmd == CMD_HEAD) begin
                            // digest keeps its value; only the valid flag drops
                            digest_ready <= 1'b0;
                            h            <= IV;
                            len          <= '0;
                            state        <= S_ACCEPT;
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_light_hash_param.sv
// -----------------------------------------------------------------------------
// tb_light_hash_param
//
// Four engine instances sharing clk/rst:
//   0: defaults (64-bit digest, 32 rounds, unroll 1, 32-bit length)
//   1: 128-bit digest, unroll 1
//   2: 128-bit digest, unroll 4
//   3: 32-bit digest, 4 rounds, unroll 2, 8-bit length
// Expected digests come from a sequential reference model whose S-box is
// derived from GF(2^8) inversion plus the AES affine map.
// -----------------------------------------------------------------------------
module tb_light_hash_param;

  localparam logic [1:0] C_HEAD = 2'b00;
  localparam logic [1:0] C_TAIL = 2'b01;
  localparam logic [1:0] C_MSG  = 2'b10;
  localparam logic [1:0] C_RSV  = 2'b11;

  localparam logic [63:0]  IV0 = 64'h0123456789ABCDEF;
  localparam logic [127:0] IV1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [31:0]  IV3 = 32'hDEADBEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         cmd_valid_w [4];
  logic         cmd_ready_w [4];
  logic [1:0]   cmd_w       [4];
  logic [7:0]   byte_w      [4];
  logic         dready_w    [4];
  logic         busy_w      [4];
  logic         perr_w      [4];
  logic [2:0]   st_w        [4];
  logic [255:0] digest_w    [4];
  logic [63:0]  dig0;
  logic [127:0] dig1;
  logic [127:0] dig2;
  logic [31:0]  dig3;

  assign digest_w[0] = {192'b0, dig0};
  assign digest_w[1] = {128'b0, dig1};
  assign digest_w[2] = {128'b0, dig2};
  assign digest_w[3] = {224'b0, dig3};

  light_hash_param #(.DIGEST_W(64), .ROUNDS(32), .UNROLL(1), .IV(IV0), .LEN_W(32)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_w[0]), .cmd_ready(cmd_ready_w[0]),
    .cmd(cmd_w[0]), .msg_byte(byte_w[0]), .digest(dig0), .digest_ready(dready_w[0]),
    .busy(busy_w[0]), .proto_err(perr_w[0]), .state_dbg(st_w[0]));

  light_hash_param #(.DIGEST_W(128), .ROUNDS(32), .UNROLL(1), .IV(IV1), .LEN_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_w[1]), .cmd_ready(cmd_ready_w[1]),
    .cmd(cmd_w[1]), .msg_byte(byte_w[1]), .digest(dig1), .digest_ready(dready_w[1]),
    .busy(busy_w[1]), .proto_err(perr_w[1]), .state_dbg(st_w[1]));

  light_hash_param #(.DIGEST_W(128), .ROUNDS(32), .UNROLL(4), .IV(IV1), .LEN_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_w[2]), .cmd_ready(cmd_ready_w[2]),
    .cmd(cmd_w[2]), .msg_byte(byte_w[2]), .digest(dig2), .digest_ready(dready_w[2]),
    .busy(busy_w[2]), .proto_err(perr_w[2]), .state_dbg(st_w[2]));

  light_hash_param #(.DIGEST_W(32), .ROUNDS(4), .UNROLL(2), .IV(IV3), .LEN_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_w[3]), .cmd_ready(cmd_ready_w[3]),
    .cmd(cmd_w[3]), .msg_byte(byte_w[3]), .digest(dig3), .digest_ready(dready_w[3]),
    .busy(busy_w[3]), .proto_err(perr_w[3]), .state_dbg(st_w[3]));

  // per-instance model parameters
  int           p_nb     [4] = '{8, 16, 16, 4};
  int           p_rounds [4] = '{32, 32, 32, 4};
  int           p_n      [4] = '{32, 32, 8, 2};
  int           p_lenw   [4] = '{32, 32, 32, 8};
  logic [255:0] p_iv     [4];

  // ---------------- scoreboard state ----------------
  logic [255:0] exp_q[$];
  logic [7:0]   msg_q[$];
  logic [7:0]   sbox_t [256];
  int           n_assert = 0;
  int           n_fail   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] m_rotl(input logic [7:0] v, input int s);
    return 8'((v << s) | (v >> (8 - s)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
      x = inv ^ m_rotl(inv, 1) ^ m_rotl(inv, 2) ^ m_rotl(inv, 3) ^ m_rotl(inv, 4) ^ 8'h63;
      sbox_t[b] = x;
    end
  endtask

  function automatic logic [255:0] m_absorb(input logic [255:0] h_in, input int nb,
                                           input int rounds, input logic [7:0] m);
    logic [255:0] h, hn;
    logic [7:0]   mr;
    h = h_in;
    for (int r = 0; r < rounds; r++) begin
      mr = m_rotl(m, r % 8);
      hn = '0;
      for (int i = 0; i < nb; i++)
        hn[8*i +: 8] = sbox_t[h[8*((i + 2) % nb) +: 8] ^ mr] ^ h[8*i +: 8];
      h = hn;
    end
    return h;
  endfunction

  function automatic logic [255:0] model(input int d);
    logic [255:0]    h;
    longint unsigned len;
    h   = p_iv[d];
    len = longint'(msg_q.size()) & ((64'd1 << p_lenw[d]) - 1);
    foreach (msg_q[i]) h = m_absorb(h, p_nb[d], p_rounds[d], msg_q[i]);
    for (int k = 0; k < p_lenw[d] / 8; k++)
      h = m_absorb(h, p_nb[d], p_rounds[d], 8'(len >> (8 * k)));
    return h;
  endfunction

  // ---------------- driver tasks ----------------
  // Returns just after (#1) the edge that accepted the command.
  task automatic send(input int d, input logic [1:0] c, input logic [7:0] b, input bit rnd);
    bit fired;
    int guard;
    fired = 1'b0;
    guard = 0;
    @(negedge clk);
    cmd_w[d]  = c;
    byte_w[d] = b;
    while (!fired && guard < 2000) begin
      cmd_valid_w[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      fired = cmd_valid_w[d] && cmd_ready_w[d];
      @(posedge clk);
      #1;
      if (!fired) begin
        guard++;
        @(negedge clk);
      end
    end
    cmd_valid_w[d] = 1'b0;
    if (!fired) chk("command accept timeout", 256'(fired), 256'd1);
  endtask

  // Counts cycles with cmd_ready low / busy high after an accepted MSG.
  task automatic measure(input int d, output int lo, output int bz);
    lo = 0;
    bz = 0;
    for (int g = 0; g < 2000; g++) begin
      @(negedge clk);
      if (!cmd_ready_w[d]) lo++;
      if (busy_w[d]) bz++;
      if (cmd_ready_w[d] && !busy_w[d]) break;
    end
  endtask

  // Number of edges after the TAIL accept until digest_ready is seen high.
  task automatic wait_digest(input int d, output int n);
    n = 0;
    while (n < 20000) begin
      @(posedge clk);
      #1;
      n++;
      if (dready_w[d]) break;
    end
    if (!dready_w[d]) chk("digest_ready timeout", 256'(dready_w[d]), 256'd1);
  endtask

  task automatic pulse_check(input int d, input string tag);
    chk({tag, " proto_err high"}, 256'(perr_w[d]), 256'd1);
    @(posedge clk);
    #1;
    chk({tag, " proto_err low"}, 256'(perr_w[d]), 256'd0);
  endtask

  task automatic load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  // HEAD, every byte of msg_q, TAIL; expected digest queued on TAIL.
  task automatic run_session(input int d, input bit rnd, input bit meas, output logic [255:0] dig);
    int lo, bz, lat;
    send(d, C_HEAD, 8'h00, rnd);
    foreach (msg_q[i]) begin
      send(d, C_MSG, msg_q[i], rnd);
      if (meas && i == 0) begin
        measure(d, lo, bz);
        chk("cmd_ready low cycles per byte", 256'(lo), 256'(p_n[d]));
        chk("busy cycles per byte", 256'(bz), 256'(p_n[d]));
      end
    end
    exp_q.push_back(model(d));
    send(d, C_TAIL, 8'h00, rnd);
    wait_digest(d, lat);
    if (meas) chk("tail to digest_ready latency", 256'(lat), 256'(p_n[d] * p_lenw[d] / 8));
    dig = digest_w[d];
    chk("digest vs model", dig, exp_q.pop_front());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [255:0] dig_a, dig_g, dig_e, dig_x, dig_1, dig_4, dig_bb, dig_rv, dig_l;

    p_iv[0] = {192'b0, IV0};
    p_iv[1] = {128'b0, IV1};
    p_iv[2] = {128'b0, IV1};
    p_iv[3] = {224'b0, IV3};
    for (int d = 0; d < 4; d++) begin
      cmd_valid_w[d] = 1'b0;
      cmd_w[d]       = C_HEAD;
      byte_w[d]      = 8'h00;
    end
    build_sbox();

    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset digest", digest_w[0], 256'd0);
    chk("reset digest_ready", 256'(dready_w[0]), 256'd0);
    chk("reset cmd_ready", 256'(cmd_ready_w[0]), 256'd1);
    chk("reset busy", 256'(busy_w[0]), 256'd0);
    chk("reset proto_err", 256'(perr_w[0]), 256'd0);

    // latency with single byte 0x41
    load_str("A");
    run_session(0, 1'b0, 1'b1, dig_a);

    // golden message
    load_str("H4rdw4r3_Tr0j4n");
    run_session(0, 1'b0, 1'b1, dig_g);

    // MSG in DONE: error pulse, digest untouched
    send(0, C_MSG, 8'h55, 1'b0);
    pulse_check(0, "msg in done");
    chk("done msg keeps digest_ready", 256'(dready_w[0]), 256'd1);
    chk("done msg keeps digest", digest_w[0], dig_g);

    // HEAD in DONE drops digest_ready on that edge, digest held
    send(0, C_HEAD, 8'h00, 1'b0);
    chk("head in done digest_ready", 256'(dready_w[0]), 256'd0);
    chk("head in done digest held", digest_w[0], dig_g);

    // empty message
    msg_q.delete();
    run_session(0, 1'b0, 1'b0, dig_e);
    n_assert++;
    assert (dig_e !== dig_g) else begin
      n_fail++;
      $error("FAIL empty vs golden digest: observed %0h expected different from %0h", dig_e, dig_g);
    end

    // reserved command inside a session
    load_str("ab");
    send(0, C_HEAD, 8'h00, 1'b0);
    send(0, C_MSG, msg_q[0], 1'b0);
    send(0, C_RSV, 8'h00, 1'b0);
    pulse_check(0, "rsv in accept");
    send(0, C_MSG, msg_q[1], 1'b0);
    exp_q.push_back(model(0));
    send(0, C_TAIL, 8'h00, 1'b0);
    begin
      int lat;
      wait_digest(0, lat);
    end
    dig_x = digest_w[0];
    chk("digest after rsv", dig_x, exp_q.pop_front());

    // reset in the middle of ROUND
    send(0, C_HEAD, 8'h00, 1'b0);
    send(0, C_MSG, 8'h42, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid-round reset digest", digest_w[0], 256'd0);
    chk("mid-round reset digest_ready", 256'(dready_w[0]), 256'd0);
    chk("mid-round reset cmd_ready", 256'(cmd_ready_w[0]), 256'd1);
    chk("mid-round reset busy", 256'(busy_w[0]), 256'd0);
    send(0, C_MSG, 8'h42, 1'b0);
    pulse_check(0, "msg in idle");

    // unroll equivalence
    load_str("3.141592653589793238");
    run_session(1, 1'b0, 1'b1, dig_1);
    run_session(2, 1'b0, 1'b1, dig_4);
    chk("unroll 4 vs unroll 1 digest", dig_4, dig_1);

    // back-pressure: back-to-back versus random valid
    run_session(0, 1'b0, 1'b0, dig_bb);
    run_session(0, 1'b1, 1'b0, dig_rv);
    chk("random valid vs back-to-back digest", dig_rv, dig_bb);

    // 8-bit length counter wraps: 257 bytes absorb length 0x01
    msg_q.delete();
    for (int i = 0; i < 257; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    run_session(3, 1'b0, 1'b1, dig_l);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
